alarm_buzzer: RTL and testbench
===============================

# alarm_buzzer

- Alarm stage downstream of the min:sec counter.
- Compares the running minute/second values against a programmed alarm time, then drives a square-wave buzzer for a bounded ring period.
- Supports stop and (optionally) snooze from debounced buttons.
- Sits beside the display path: it consumes the same counter outputs and the 1 Hz tick, and its buzzer output goes straight to a pin.

## Interface
Parameters:
- TONE_DIV, 50000 — clk cycles per buzzer period; must be even and ≥ 2 (1 kHz at 50 MHz).
- RING_SEC, 60 — seconds of ringing before auto-stop; range 1..255.
- SNOOZE_SEC, 300 — seconds of silence before re-ring; range 1..1023.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_sec_tick  in  1  one-clk pulse per counted second, in the clk domain.
- i_sec  in  6  current seconds, 0..59.
- i_min  in  6  current minutes, 0..59.
- i_alarm_sec  in  6  alarm seconds.
- i_alarm_min  in  6  alarm minutes.
- i_alarm_en  in  1  alarm armed, level.
- i_stop  in  1  debounced one-clk pulse.
- i_snooze  in  1  debounced one-clk pulse.
- o_buzz  out  1  buzzer square wave, registered.
- o_ringing  out  1  high in RING, registered.
- o_state  out  2  0=IDLE, 1=RING, 2=SNOOZE.

## Operation
- States: IDLE, RING, SNOOZE.
- Match condition: i_sec_tick && i_alarm_en && i_min==i_alarm_min && i_sec==i_alarm_sec.
  - Match is evaluated only on the tick, so it fires once per match second.
- IDLE -> RING on match. The second counter and tone divider are cleared.
- RING:
  - The tone divider counts 0..TONE_DIV/2-1, then wraps and o_buzz toggles.
  - Each i_sec_tick increments the ring counter.
  - On the tick that makes ring count == RING_SEC -> IDLE.
- SNOOZE:
  - o_buzz=0.
  - Each i_sec_tick increments the snooze counter.
  - On the tick that makes count == SNOOZE_SEC -> RING, with counters cleared.
- Event priority, highest first: rst, !i_alarm_en, i_stop, i_snooze, timeout, match.
- Transitions by event:
  - !i_alarm_en: any state -> IDLE.
  - i_stop: RING or SNOOZE -> IDLE.
  - i_snooze: RING -> SNOOZE; ignored in IDLE and SNOOZE.
  - Match while in RING or SNOOZE: ignored.
- The counter state is treated as independent. If the set time is jumped over the alarm value, no alarm fires.
- Leaving RING for any reason forces o_buzz=0 on the same edge.

## Timing
- Reset values: state IDLE, o_buzz=0, o_ringing=0, o_state=0, all counters 0.
- Reset mid-ring silences o_buzz on the first clk edge with rst=1.
- Every transition takes effect on the clk edge where the event is sampled. o_state and o_ringing reflect it in the same cycle.
- o_buzz:
  - It is 0 on RING entry.
  - It first rises TONE_DIV/2 cycles after entry.
  - Its period is exactly TONE_DIV cycles with a 50% duty cycle.
- Ring duration is RING_SEC ticks, counted from the tick after entry. The entry tick itself is not counted.
- A simultaneous i_stop and i_snooze resolves as stop.
- A simultaneous timeout and i_snooze resolves as snooze.
- Counter widths: ring 8 bits, snooze 10 bits. No wrap is possible within the parameter ranges.

## Configuration
- ALARM_SNOOZE_EN defined:
  - The SNOOZE state, snooze counter and i_snooze handling are compiled in.
- ALARM_SNOOZE_EN undefined:
  - i_snooze is ignored and the snooze counter is absent.
  - o_state never equals 2; RING exits only by stop, disable or timeout.
  - The port list is unchanged.

## Structure
- Shared package alarm_pkg holds:
  - the state enum (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2);
  - the ring counter width of 8 and the snooze counter width of 10.
- One sub-module, tone_gen:
  - Inputs: clk, rst, synchronous clear, enable.
  - Output: registered square wave, period TONE_DIV.
  - The FSM instantiates it and gates its enable with RING.

## Test plan
Bench parameters: TONE_DIV=10, RING_SEC=3, SNOOZE_SEC=2, tick every 20 clk.

- Alarm 01:05 enabled, counters reach 01:05 on tick -> o_state=1 next edge. o_buzz rises 5 clk later and toggles every 5 clk. Back to IDLE on the 3rd following tick with o_buzz=0.
- i_alarm_en=0 with matching time -> stays IDLE, o_buzz never 1. Disable asserted mid-RING -> IDLE the same edge.
- i_stop pulse 7 clk into RING -> IDLE next edge, o_buzz=0, no retrigger until the next match tick.
- With ALARM_SNOOZE_EN: i_snooze in RING -> SNOOZE, silent. RING re-entered on the 2nd tick, and the tone restarts from phase 0.
- Without ALARM_SNOOZE_EN: the same i_snooze is ignored, RING continues, o_state never reads 2.
- Same-cycle i_stop+i_snooze -> IDLE. rst asserted mid-RING -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm stage: FSM state encoding, counter widths
// and the alarm-time compare helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_e;

  localparam int RING_CNT_W   = 8;
  localparam int SNOOZE_CNT_W = 10;

  function automatic logic time_match(
    input logic [5:0] cur_min,
    input logic [5:0] cur_sec,
    input logic [5:0] alarm_min,
    input logic [5:0] alarm_sec
  );
    return (cur_min == alarm_min) && (cur_sec == alarm_sec);
  endfunction

endpackage

// File: rtl/alarm_buzzer_tone_gen.sv
// Square-wave generator (module tone_gen): period TONE_DIV clk cycles, 50% duty.
// Output is held low while disabled or cleared, and restarts from phase 0.
module tone_gen #(
  parameter int TONE_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic buzz
);

  localparam int HALF  = TONE_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div_cnt;

  // First rising edge arrives HALF cycles after the cycle in which en goes high.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      div_cnt <= '0;
      buzz    <= 1'b0;
    end else if (div_cnt == HALF_M1) begin
      div_cnt <= '0;
      buzz    <= ~buzz;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_buzzer.sv
// Alarm stage: compares min:sec against the programmed alarm on each 1 Hz tick and
// rings a buzzer for RING_SEC seconds. Define ALARM_SNOOZE_EN to build the SNOOZE state.
module alarm_buzzer
  import alarm_pkg::*;
#(
  parameter int TONE_DIV   = 50000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sec_tick,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [5:0] i_alarm_sec,
  input  logic [5:0] i_alarm_min,
  input  logic       i_alarm_en,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic       o_buzz,
  output logic       o_ringing,
  output logic [1:0] o_state
);

  // i_sec_tick, i_stop and i_snooze are single-cycle strobes with no backpressure:
  // each one is acted on in the cycle it is high and never held or queued.

  localparam logic [RING_CNT_W-1:0] RING_LIM = RING_CNT_W'(RING_SEC);

  alarm_state_e          state, state_nxt;
  logic [RING_CNT_W-1:0] ring_cnt, ring_cnt_nxt, ring_inc;
  logic                  match;
  logic                  ringing_q;
  logic                  tone_en, tone_clr;

  assign match    = i_sec_tick && i_alarm_en &&
                    time_match(i_min, i_sec, i_alarm_min, i_alarm_sec);
  assign ring_inc = ring_cnt + 1'b1;

`ifdef ALARM_SNOOZE_EN
  localparam logic [SNOOZE_CNT_W-1:0] SNOOZE_LIM = SNOOZE_CNT_W'(SNOOZE_SEC);

  logic [SNOOZE_CNT_W-1:0] snooze_cnt, snooze_cnt_nxt, snooze_inc;

  assign snooze_inc = snooze_cnt + 1'b1;
`else
  logic unused_snooze;

  assign unused_snooze = i_snooze | (SNOOZE_SEC == 0);
`endif

  // Priority: disable, stop, snooze, timeout, match.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_nxt = snooze_cnt;
`endif
    if (!i_alarm_en) begin
      state_nxt    = ST_IDLE;
      ring_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_nxt = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            state_nxt    = ST_RING;
            ring_cnt_nxt = '0;
          end
        end
        ST_RING: begin
          if (i_stop) begin
            state_nxt    = ST_IDLE;
            ring_cnt_nxt = '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (i_snooze) begin
            state_nxt      = ST_SNOOZE;
            ring_cnt_nxt   = '0;
            snooze_cnt_nxt = '0;
          end
`endif
          else if (i_sec_tick) begin
            if (ring_inc == RING_LIM) begin
              state_nxt    = ST_IDLE;
              ring_cnt_nxt = '0;
            end else begin
              ring_cnt_nxt = ring_inc;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (i_stop) begin
            state_nxt      = ST_IDLE;
            snooze_cnt_nxt = '0;
          end else if (i_sec_tick) begin
            if (snooze_inc == SNOOZE_LIM) begin
              state_nxt      = ST_RING;
              ring_cnt_nxt   = '0;
              snooze_cnt_nxt = '0;
            end else begin
              snooze_cnt_nxt = snooze_inc;
            end
          end
        end
`endif
        default: begin
          state_nxt    = ST_IDLE;
          ring_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ring_cnt  <= '0;
      ringing_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ring_cnt  <= ring_cnt_nxt;
      ringing_q <= (state_nxt == ST_RING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      snooze_cnt <= '0;
    end else begin
      snooze_cnt <= snooze_cnt_nxt;
    end
  end
`endif

  // Driving the tone from the next state silences it on the very edge RING is left,
  // and restarts it from phase 0 on every RING entry.
  assign tone_en  = (state_nxt == ST_RING);
  assign tone_clr = (state != ST_RING) && (state_nxt == ST_RING);

  tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .clr  (tone_clr),
    .en   (tone_en),
    .buzz (o_buzz)
  );

  assign o_ringing = ringing_q;
  assign o_state   = state;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Self-checking bench for alarm_buzzer: directed scenarios plus a randomized phase,
// compared cycle by cycle against a time-based behavioural model.
module tb_alarm_buzzer;

  localparam int TONE_DIV    = 10;
  localparam int RING_SEC    = 3;
  localparam int SNOOZE_SEC  = 2;
  localparam int TICK_PERIOD = 20;
  localparam int HALF        = TONE_DIV / 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_sec_tick = 1'b0;
  logic [5:0] i_sec = '0;
  logic [5:0] i_min = '0;
  logic [5:0] i_alarm_sec = '0;
  logic [5:0] i_alarm_min = '0;
  logic       i_alarm_en = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_snooze = 1'b0;
  logic       o_buzz;
  logic       o_ringing;
  logic [1:0] o_state;

  alarm_buzzer #(
    .TONE_DIV   (TONE_DIV),
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sec_tick  (i_sec_tick),
    .i_sec       (i_sec),
    .i_min       (i_min),
    .i_alarm_sec (i_alarm_sec),
    .i_alarm_min (i_alarm_min),
    .i_alarm_en  (i_alarm_en),
    .i_stop      (i_stop),
    .i_snooze    (i_snooze),
    .o_buzz      (o_buzz),
    .o_ringing   (o_ringing),
    .o_state     (o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];   // {state, ringing, buzz}, one entry per clk edge

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode 0/1/2 = idle/ring/snooze; buzz derived from time elapsed since ring entry.
  logic [1:0] m_st = 2'd0;
  int m_tk = 0;
  int cyc = 0;
  int ring_t0 = 0;

  task automatic model_step();
    logic m_match;
    logic m_buzz;
    cyc++;
    m_match = i_sec_tick && i_alarm_en && (i_min == i_alarm_min) && (i_sec == i_alarm_sec);
    if (rst || !i_alarm_en) m_st = 2'd0;
    else if (m_st != 2'd0 && i_stop) m_st = 2'd0;
    else if (SNZ && m_st == 2'd1 && i_snooze) begin
      m_st = 2'd2;
      m_tk = 0;
    end else if (m_st != 2'd0 && i_sec_tick) begin
      m_tk++;
      if (m_st == 2'd1 && m_tk == RING_SEC) m_st = 2'd0;
      else if (m_st == 2'd2 && m_tk == SNOOZE_SEC) begin
        m_st = 2'd1;
        m_tk = 0;
        ring_t0 = cyc;
      end
    end else if (m_st == 2'd0 && m_match) begin
      m_st = 2'd1;
      m_tk = 0;
      ring_t0 = cyc;
    end
    m_buzz = (m_st == 2'd1) && ((((cyc - ring_t0) / HALF) % 2) == 1);
    exp_q.push_back({m_st, m_st == 2'd1, m_buzz});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("state",   32'(o_state),   32'(e[3:2]));
      check_eq("ringing", 32'(o_ringing), 32'(e[1]));
      check_eq("buzz",    32'(o_buzz),    32'(e[0]));
    end
  end

  // ---------------- drivers ----------------
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  int tick_div = 0;
  bit jump_mode = 1'b0;

  task automatic set_time(input logic [5:0] m, input logic [5:0] s);
    cur_min  = m;
    cur_sec  = s;
    tick_div = 0;
  endtask

  task automatic drive_cycle(input logic stop, input logic snz);
    @(negedge clk);
    i_stop   = stop;
    i_snooze = snz;
    if (tick_div == TICK_PERIOD - 1) begin
      tick_div   = 0;
      i_sec_tick = 1'b1;
      if (cur_sec == 6'd59) begin
        cur_sec = '0;
        cur_min = (cur_min == 6'd59) ? 6'd0 : 6'(cur_min + 6'd1);
      end else begin
        cur_sec = 6'(cur_sec + 6'd1);
      end
      if (jump_mode && $urandom_range(0, 3) == 0) cur_sec = 6'(cur_sec + 6'd1);
      if (jump_mode && cur_sec >= 6'd9) cur_sec = 6'($urandom_range(0, 4));
    end else begin
      tick_div++;
      i_sec_tick = 1'b0;
    end
    i_sec = cur_sec;
    i_min = cur_min;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic wait_mode(input logic [1:0] target, input int budget, input string tag);
    int n = 0;
    while (m_st != target && n < budget) begin
      drive_cycle(1'b0, 1'b0);
      n++;
    end
    check_eq(tag, 32'(m_st), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_alarm_min = 6'd1;
    i_alarm_sec = 6'd5;
    i_alarm_en  = 1'b1;
    set_time(6'd1, 6'd2);
    idle(4);
    rst = 1'b0;

    // full ring to timeout
    wait_mode(2'd1, 200, "wait_ring_full");
    idle(100);

    // disabled alarm with matching time
    i_alarm_en = 1'b0;
    set_time(6'd1, 6'd3);
    idle(80);
    i_alarm_en = 1'b1;

    // disable mid-ring
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_dis");
    idle(12);
    i_alarm_en = 1'b0;
    idle(3);
    i_alarm_en = 1'b1;
    idle(20);

    // stop about 7 clk into ring
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_stop");
    idle(6);
    drive_cycle(1'b1, 1'b0);
    idle(80);

    // snooze, re-ring, timeout
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_snz");
    idle(6);
    drive_cycle(1'b0, 1'b1);
    idle(150);

    // stop and snooze together
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_both");
    idle(4);
    drive_cycle(1'b1, 1'b1);
    idle(30);

    // snooze then stop while snoozing
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_snzstop");
    idle(3);
    drive_cycle(1'b0, 1'b1);
    idle(10);
    drive_cycle(1'b1, 1'b0);
    idle(20);

    // snooze on the timeout tick
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_tmo_snz");
    idle(58);
    drive_cycle(1'b0, 1'b1);
    idle(120);

    // reset mid-ring
    set_time(6'd1, 6'd3);
    wait_mode(2'd1, 200, "wait_ring_rst");
    idle(8);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(20);

    // randomized phase with time jumps around the alarm second
    jump_mode = 1'b1;
    set_time(6'd1, 6'd0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) i_alarm_en = ~i_alarm_en;
      rst = ($urandom_range(0, 599) == 0);
      drive_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;
    i_alarm_en = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
